fp_addsub_seq: RTL and testbench
================================

# fp_addsub_seq

Multi-cycle IEEE-754 single-precision add/subtract unit built around a sequencing state machine. It accepts one operand pair through a valid/ready handshake, then walks the operation through align, add/subtract, normalize and pack steps. It holds the packed result on a valid/ready output port until the result is taken. It sits between the FPU issue logic and the result writeback path, sharing the normalizer datapath with the rest of the floating-point ALU.

## Interface
- No parameters; format is fixed binary32: 1 sign bit, 8 exponent bits, 23 fraction bits.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  high only in IDLE; an operation is accepted when in_valid && in_ready.
- a  in  32  operand A.
- b  in  32  operand B.
- op  in  1  0 = A+B, 1 = A−B.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result when out_valid && out_ready.
- result  out  32  packed result; stable while out_valid is high.
- busy  out  1  high in every state except IDLE.

## Operation
States: IDLE → ALIGN → ADD → NORM → DONE → IDLE.

- **IDLE**
  - On accept, register a, and b with its sign XORed with op.
- **Special inputs**
  - Exponent 255 on either operand → result 0x7FC00000.
  - Exponent 0 on an operand → that operand is +0 (denormals flushed).
  - Special cases skip straight to DONE on the next edge.
- **ALIGN** (1 cycle)
  - Swap the operands so |L| ≥ |S|, comparing {exp, frac}.
  - Form 24-bit significands with the hidden 1.
  - Right-shift S by d = expL − expS; if d ≥ 24, S becomes 0.
  - Shifted-out bits are truncated; there is no rounding.
- **ADD** (1 cycle)
  - Equal signs: 25-bit sum = L + S.
  - Otherwise: L − S, which is never negative.
- **NORM**
  - sum[24] = 1: shift right by 1 and add 1 to exp (truncating).
  - sum == 0: result is +0x00000000.
  - Otherwise: shift left until sum[23] = 1, decrementing exp once per bit.
  - Exp reaching ≤ 0 → ±0.
  - Exp reaching 255 → ±infinity (exp 255, frac 0).
  - Result sign = sign of L; exact cancellation gives +0.
- **DONE**
  - out_valid = 1 and result is driven.
  - On out_ready, return to IDLE.
  - The next accept can happen no earlier than the cycle after the handoff.

## Timing
- Reset values: out_valid 0, result 0, busy 0, in_ready 1, state IDLE.
- rst_n asserted in any state aborts the operation immediately; no partial result is ever presented.
- Combinational normalization: NORM takes 1 cycle. out_valid rises on the 4th edge after the accept edge.
- Iterative normalization: NORM takes max(1, k) cycles for k left shifts (up to 23). Latency is 3 + max(1, k) edges.
- in_valid is ignored while busy; operands are not required to stay stable after accept.
- With out_ready held high, out_valid is high for exactly one cycle.
- result and out_valid do not change while out_valid && !out_ready.

## Configuration
- Macro: FP_ITER_NORM_EN.
- Defined: NORM shifts left one bit per cycle, so latency depends on the data. This gives the smallest area.
- Undefined: NORM does the full leading-zero count and shift in one cycle, for a fixed latency of 4.
- Results are bit-identical in both builds.

## Structure
- Package fp_pkg:
  - state enum.
  - Field widths EXP_W = 8, FRAC_W = 23, SIG_W = 24.
  - Constants: QNAN = 32'h7FC00000, EXP_MAX = 8'hFF.
- Sub-module fp_norm_lzc: combinational leading-zero count plus left shift of the 25-bit sum. It returns the shifted significand and the shift amount (5 bits).
  - Used in NORM when FP_ITER_NORM_EN is undefined.
  - The iterative build uses a 1-bit shifter instead.

## Test plan
- 0x3F800000 + 0x3F800000, op = 0 → 0x40000000; out_valid on the 4th edge after accept (non-iterative build).
- 0x3F800000 − 0x3F800000 → 0x00000000; 0xBF800000 + 0x3F800000 → 0x00000000.
- 0x40400000 − 0x403FFFFF → 0x34800000; the iterative build spends 23 cycles in NORM.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000; 0x7FC00000 + 0x3F800000 → 0x7FC00000.
- Backpressure: out_ready held low for 5 cycles → result stable, in_ready 0, and an in_valid pulse in that window is not accepted.
- Reset mid-operation: rst_n pulsed low during NORM → outputs return to reset values at once. A following 0x40000000 + 0x3F800000 → 0x40400000.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and constants for the binary32 add/subtract unit.
package fp_pkg;

   localparam int unsigned EXP_W  = 8;
   localparam int unsigned FRAC_W = 23;
   localparam int unsigned SIG_W  = 24;

   localparam logic [31:0]      QNAN    = 32'h7FC00000;
   localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

   typedef enum logic [2:0] {
      StIdle,
      StAlign,
      StAdd,
      StNorm,
      StDone
   } state_e;

   // Denormals and zeros collapse to +0.
   function automatic logic [31:0] flush_zero(input logic [31:0] x);
      return (x[30:23] == '0) ? 32'h0 : x;
   endfunction

endpackage

// File: rtl/fp_norm_lzc.sv
// Leading-zero count and left shift of the 25-bit add/sub result.
// A set carry bit (sum_i[24]) yields the right-shifted significand with a zero shift count.
module fp_norm_lzc
   import fp_pkg::*;
(
   input  logic [SIG_W:0]   sum_i,
   output logic [SIG_W-1:0] sig_o,
   output logic [4:0]       shamt_o
);

   // Highest set bit in sum_i[23:0] determines the shift toward bit 23.
   always_comb begin
      shamt_o = '0;
      for (int i = 0; i < SIG_W; i++) begin
         if (sum_i[i]) shamt_o = 5'(SIG_W - 1 - i);
      end
      if (sum_i[SIG_W]) begin
         shamt_o = '0;
         sig_o   = sum_i[SIG_W:1];
      end else begin
         sig_o = sum_i[SIG_W-1:0] << shamt_o;
      end
   end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle binary32 add/subtract: IDLE -> ALIGN -> ADD -> NORM -> DONE.
// Truncating (no rounding), denormals flushed to +0, any exp-255 input yields QNAN.
// Build option FP_ITER_NORM_EN: normalize one bit per cycle instead of a single-cycle LZC shift.
module fp_addsub_seq
   import fp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        op,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        busy
);

   state_e state_q, state_d;

   logic [31:0]       a_q, a_d, b_q, b_d;
   logic              sign_q, sign_d, sub_q, sub_d;
   logic [EXP_W-1:0]  exp_q, exp_d;
   logic [SIG_W-1:0]  sig_l_q, sig_l_d, sig_s_q, sig_s_d;
   logic [SIG_W:0]    sum_q, sum_d;
   logic [31:0]       result_q, result_d;

   logic              special;
   logic              norm_done;
   logic              swap;
   logic [31:0]       op_l, op_s;
   logic [EXP_W-1:0]  exp_diff;
   logic [SIG_W-1:0]  sig_s_full;
   logic [EXP_W-1:0]  exp_inc;

`ifdef FP_ITER_NORM_EN
   logic [SIG_W:0]    sum_sh;
   logic [EXP_W-1:0]  exp_dec;
`else
   logic [SIG_W-1:0]  lz_sig;
   logic [4:0]        lz_shamt;

   fp_norm_lzc u_norm_lzc (
      .sum_i   (sum_q),
      .sig_o   (lz_sig),
      .shamt_o (lz_shamt)
   );
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Next-state sequencing.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (in_valid) state_d = special ? StDone : StAlign;
         StAlign: state_d = StAdd;
         StAdd:   state_d = StNorm;
         StNorm:  if (norm_done) state_d = StDone;
         StDone:  if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Handshake outputs decoded from state.
   always_comb begin
      in_ready  = (state_q == StIdle);
      busy      = (state_q != StIdle);
      out_valid = (state_q == StDone);
   end

   assign result = result_q;

   // Operand ordering for ALIGN; magnitudes compare as {exp, frac}.
   always_comb begin
      swap       = (b_q[30:0] > a_q[30:0]);
      op_l       = swap ? b_q : a_q;
      op_s       = swap ? a_q : b_q;
      exp_diff   = op_l[30:23] - op_s[30:23];
      sig_s_full = {|op_s[30:23], op_s[22:0]};
      exp_inc    = exp_q + 8'd1;
`ifdef FP_ITER_NORM_EN
      sum_sh     = {sum_q[SIG_W-1:0], 1'b0};
      exp_dec    = exp_q - 8'd1;
`endif
   end

   // Datapath next-state for each step.
   always_comb begin
      a_d       = a_q;
      b_d       = b_q;
      sign_d    = sign_q;
      sub_d     = sub_q;
      exp_d     = exp_q;
      sig_l_d   = sig_l_q;
      sig_s_d   = sig_s_q;
      sum_d     = sum_q;
      result_d  = result_q;
      special   = 1'b0;
      norm_done = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d = flush_zero(a);
               b_d = flush_zero({b[31] ^ op, b[30:0]});
               if (a[30:23] == EXP_MAX || b[30:23] == EXP_MAX) begin
                  special  = 1'b1;
                  result_d = QNAN;
               end
            end
         end
         StAlign: begin
            sign_d  = op_l[31];
            sub_d   = a_q[31] ^ b_q[31];
            exp_d   = op_l[30:23];
            sig_l_d = {|op_l[30:23], op_l[22:0]};
            sig_s_d = (exp_diff >= 8'd24) ? '0 : (sig_s_full >> exp_diff);
         end
         StAdd: begin
            sum_d = sub_q ? ({1'b0, sig_l_q} - {1'b0, sig_s_q})
                          : ({1'b0, sig_l_q} + {1'b0, sig_s_q});
         end
         StNorm: begin
`ifdef FP_ITER_NORM_EN
            norm_done = 1'b1;
            if (sum_q[SIG_W]) begin
               if (exp_inc == EXP_MAX) result_d = {sign_q, EXP_MAX, 23'h0};
               else                    result_d = {sign_q, exp_inc, sum_q[SIG_W-1:1]};
            end else if (sum_q == '0) begin
               result_d = 32'h0;
            end else if (sum_q[SIG_W-1]) begin
               result_d = {sign_q, exp_q, sum_q[FRAC_W-1:0]};
            end else if (exp_dec == '0) begin
               result_d = {sign_q, 31'h0};
            end else if (sum_sh[SIG_W-1]) begin
               result_d = {sign_q, exp_dec, sum_sh[FRAC_W-1:0]};
            end else begin
               // Not yet normalized: one more shift next cycle.
               norm_done = 1'b0;
               sum_d     = sum_sh;
               exp_d     = exp_dec;
            end
`else
            norm_done = 1'b1;
            if (sum_q[SIG_W]) begin
               if (exp_inc == EXP_MAX) result_d = {sign_q, EXP_MAX, 23'h0};
               else                    result_d = {sign_q, exp_inc, lz_sig[FRAC_W-1:0]};
            end else if (sum_q == '0) begin
               result_d = 32'h0;
            end else if (exp_q <= {3'b0, lz_shamt}) begin
               result_d = {sign_q, 31'h0};
            end else begin
               result_d = {sign_q, exp_q - {3'b0, lz_shamt}, lz_sig[FRAC_W-1:0]};
            end
`endif
         end
         StDone: ;
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         sign_q   <= 1'b0;
         sub_q    <= 1'b0;
         exp_q    <= '0;
         sig_l_q  <= '0;
         sig_s_q  <= '0;
         sum_q    <= '0;
         result_q <= '0;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         sign_q   <= sign_d;
         sub_q    <= sub_d;
         exp_q    <= exp_d;
         sig_l_q  <= sig_l_d;
         sig_s_q  <= sig_s_d;
         sum_q    <= sum_d;
         result_q <= result_d;
      end
   end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq; latency expectations follow FP_ITER_NORM_EN.
module tb_fp_addsub_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        op;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        busy;

   int errors = 0;
   int checks = 0;
   int lat;

   always #5 clk = ~clk;

   fp_addsub_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // One full transaction with out_ready high; latency counts edges from the accept edge.
   task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic opv, input logic [31:0] expv,
                         input int lat_c, input int lat_i);
      int want;
      int l;
`ifdef FP_ITER_NORM_EN
      want = lat_i;
`else
      want = lat_c;
`endif
      @(negedge clk);
      a = av; b = bv; op = opv; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = $urandom; b = $urandom; op = 1'($urandom_range(0, 1));
      check({tag, " busy"}, {31'h0, busy}, 32'd1);
      l = 1;
      while (!out_valid && l < 60) begin
         @(posedge clk); #1;
         l++;
      end
      check({tag, " lat"}, 32'(l), 32'(want));
      check({tag, " res"}, result, expv);
      @(posedge clk); #1;
      check({tag, " drop"}, {31'h0, out_valid}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; op = 1'b0;
      #12;
      check("rst out_valid", {31'h0, out_valid}, 32'd0);
      check("rst result", result, 32'h0);
      check("rst busy", {31'h0, busy}, 32'd0);
      check("rst in_ready", {31'h0, in_ready}, 32'd1);
      @(negedge clk); rst_n = 1'b1;

      run_op("1+1", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4, 4);
      run_op("1-1", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4, 4);
      run_op("-1+1", 32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000, 4, 4);
      run_op("3-3ulp", 32'h40400000, 32'h403FFFFF, 1'b1, 32'h34800000, 4, 26);
      run_op("ovf", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4, 4);
      run_op("nan", 32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 1, 1);
      run_op("2-1", 32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 4, 4);
      run_op("denorm", 32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 4, 4);
      run_op("trunc", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4, 4);
      run_op("3+-2", 32'h40400000, 32'hC0000000, 1'b0, 32'h3F800000, 4, 4);
      run_op("-3+2", 32'hC0400000, 32'h40000000, 1'b0, 32'hBF800000, 4, 4);
      run_op("1--1", 32'h3F800000, 32'hBF800000, 1'b1, 32'h40000000, 4, 4);

      // Backpressure: result held, input side closed, stray in_valid ignored.
      out_ready = 1'b0;
      @(negedge clk);
      a = 32'h3F800000; b = 32'h3F800000; op = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      check("bp res", result, 32'h40000000);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 2) begin
            in_valid = 1'b1; a = 32'h40400000; b = 32'h3F800000; op = 1'b0;
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk); #1;
         check("bp hold valid", {31'h0, out_valid}, 32'd1);
         check("bp hold res", result, 32'h40000000);
         check("bp in_ready", {31'h0, in_ready}, 32'd0);
      end
      @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp handoff valid", {31'h0, out_valid}, 32'd0);
      check("bp handoff busy", {31'h0, busy}, 32'd0);
      @(posedge clk); #1;
      check("bp not accepted", {31'h0, busy}, 32'd0);

      // Reset while in NORM.
      @(negedge clk);
      a = 32'h40400000; b = 32'h403FFFFF; op = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("mid busy", {31'h0, busy}, 32'd1);
      check("mid valid", {31'h0, out_valid}, 32'd0);
      #1 rst_n = 1'b0;
      #1;
      check("arst valid", {31'h0, out_valid}, 32'd0);
      check("arst result", result, 32'h0);
      check("arst busy", {31'h0, busy}, 32'd0);
      check("arst in_ready", {31'h0, in_ready}, 32'd1);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("post rst valid", {31'h0, out_valid}, 32'd0);
      check("post rst busy", {31'h0, busy}, 32'd0);
      run_op("2+1", 32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 4, 4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
